// File: rtl/uart_packet_tx.sv
// Frames a buffered payload as SYNC, LEN, payload bytes, CHK and hands each byte to a
// UART transmitter using a ready/enable handshake.
module uart_packet_tx #(
    parameter int unsigned MAX_PAYLOAD = 16,
    parameter logic [7:0]  SYNC_BYTE   = 8'hAA
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] PayloadData,
    input  logic       PayloadValid,
    output logic       PayloadReady,
    input  logic       PacketSend,
    output logic       Busy,
    output logic [7:0] UartTxData,
    output logic       UartTxEnable,
    input  logic       UartTxReady
);

    localparam int unsigned AW      = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
    localparam logic [7:0]  MAX_CNT = 8'(MAX_PAYLOAD);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_HDR     = 3'd1;
    localparam logic [2:0] ST_LEN     = 3'd2;
    localparam logic [2:0] ST_PAYLOAD = 3'd3;
    localparam logic [2:0] ST_CHK     = 3'd4;

    localparam logic [1:0] BY_ISSUE     = 2'd0;
    localparam logic [1:0] BY_WAIT_LOW  = 2'd1;
    localparam logic [1:0] BY_WAIT_HIGH = 2'd2;

    logic [2:0] state_q, state_d;
    logic [1:0] byte_q, byte_d;
    logic [7:0] count_q, count_d;
    logic [7:0] rd_ptr_q, rd_ptr_d;
    logic [7:0] xor_q, xor_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       tx_en_q, tx_en_d;

    logic [7:0] mem_q [MAX_PAYLOAD];
    logic       write_en;
    logic [7:0] cur_byte;

    assign PayloadReady = (state_q == ST_IDLE) && (count_q < MAX_CNT);
    assign write_en     = PayloadValid && PayloadReady;
    assign Busy         = (state_q != ST_IDLE);
    assign UartTxData   = tx_data_q;
    assign UartTxEnable = tx_en_q;

    // Byte presented to the UART for the current top-level state.
    always_comb begin
        cur_byte = 8'h00;
        case (state_q)
            ST_HDR:     cur_byte = SYNC_BYTE;
            ST_LEN:     cur_byte = count_q;
            ST_PAYLOAD: cur_byte = mem_q[rd_ptr_q[AW-1:0]];
            ST_CHK:     cur_byte = xor_q ^ count_q;
            default:    cur_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        byte_d    = byte_q;
        count_d   = count_q;
        rd_ptr_d  = rd_ptr_q;
        xor_d     = xor_q;
        tx_data_d = tx_data_q;
        tx_en_d   = 1'b0;

        if (state_q == ST_IDLE) begin
            if (write_en) begin
                count_d = count_q + 8'd1;
                xor_d   = xor_q ^ PayloadData;
            end
            if (PacketSend) begin
                state_d = ST_HDR;
                byte_d  = BY_ISSUE;
            end
        end else begin
            case (byte_q)
                BY_ISSUE: begin
                    if (UartTxReady) begin
                        tx_en_d   = 1'b1;
                        tx_data_d = cur_byte;
                        byte_d    = BY_WAIT_LOW;
                    end
                end
                BY_WAIT_LOW: begin
                    if (!UartTxReady) begin
                        byte_d = BY_WAIT_HIGH;
                    end
                end
                BY_WAIT_HIGH: begin
                    // UART is idle again: the byte is done, move to the next one.
                    if (UartTxReady) begin
                        byte_d = BY_ISSUE;
                        case (state_q)
                            ST_HDR: state_d = ST_LEN;
                            ST_LEN: state_d = (count_q == 8'd0) ? ST_CHK : ST_PAYLOAD;
                            ST_PAYLOAD: begin
                                rd_ptr_d = rd_ptr_q + 8'd1;
                                if (rd_ptr_q + 8'd1 == count_q) begin
                                    state_d = ST_CHK;
                                end
                            end
                            ST_CHK: begin
                                state_d  = ST_IDLE;
                                count_d  = 8'd0;
                                rd_ptr_d = 8'd0;
                                xor_d    = 8'd0;
                            end
                            default: state_d = ST_IDLE;
                        endcase
                    end
                end
                default: byte_d = BY_ISSUE;
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            byte_q    <= BY_ISSUE;
            count_q   <= 8'd0;
            rd_ptr_q  <= 8'd0;
            xor_q     <= 8'd0;
            tx_data_q <= 8'h00;
            tx_en_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            byte_q    <= byte_d;
            count_q   <= count_d;
            rd_ptr_q  <= rd_ptr_d;
            xor_q     <= xor_d;
            tx_data_q <= tx_data_d;
            tx_en_q   <= tx_en_d;
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge Clk) begin
        if (write_en) begin
            mem_q[count_q[AW-1:0]] <= PayloadData;
        end
    end

endmodule

// File: tb/tb_uart_packet_tx.sv
// Directed bench for uart_packet_tx with a behavioural UART ready/enable model.
module tb_uart_packet_tx;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic [7:0] PayloadData = 8'h00;
    logic       PayloadValid = 1'b0;
    logic       PacketSend = 1'b0;
    logic       UartTxReady = 1'b1;
    logic       PayloadReady;
    logic       Busy;
    logic [7:0] UartTxData;
    logic       UartTxEnable;

    int errors = 0;
    int checks = 0;

    logic [7:0] cap_q [$];
    int   pulses = 0;
    int   consec_err = 0;
    int   hold_err = 0;
    int   uart_hold = 0;
    int   hold_left = 0;
    int   low_left = 0;
    logic prev_en = 1'b0;
    logic [7:0] last_data = 8'h00;

    uart_packet_tx #(.MAX_PAYLOAD(16), .SYNC_BYTE(8'hAA)) dut (
        .Clk(Clk),
        .Reset(Reset),
        .PayloadData(PayloadData),
        .PayloadValid(PayloadValid),
        .PayloadReady(PayloadReady),
        .PacketSend(PacketSend),
        .Busy(Busy),
        .UartTxData(UartTxData),
        .UartTxEnable(UartTxEnable),
        .UartTxReady(UartTxReady)
    );

    always #5 Clk = ~Clk;

    // UART model: captures on enable, optionally stays ready for uart_hold cycles, then
    // goes busy for 3 cycles.
    always @(negedge Clk) begin
        if (Reset) begin
            hold_left   = 0;
            low_left    = 0;
            UartTxReady = 1'b1;
            prev_en     = 1'b0;
        end else begin
            if (UartTxEnable) begin
                cap_q.push_back(UartTxData);
                pulses++;
                if (prev_en) consec_err++;
                last_data = UartTxData;
                if (uart_hold == 0) begin
                    UartTxReady = 1'b0;
                    low_left    = 3;
                end else begin
                    hold_left = uart_hold;
                end
            end else if (hold_left > 0) begin
                if (UartTxData !== last_data) hold_err++;
                hold_left--;
                if (hold_left == 0) begin
                    UartTxReady = 1'b0;
                    low_left    = 3;
                end
            end else if (low_left > 0) begin
                if (UartTxData !== last_data) hold_err++;
                low_left--;
                if (low_left == 0) UartTxReady = 1'b1;
            end
            prev_en = UartTxEnable;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic write_byte(input logic [7:0] d);
        @(negedge Clk);
        PayloadData  = d;
        PayloadValid = 1'b1;
        @(negedge Clk);
        PayloadValid = 1'b0;
    endtask

    task automatic send_packet();
        @(negedge Clk);
        PacketSend = 1'b1;
        @(negedge Clk);
        PacketSend = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge Clk);
            if (!Busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (3) @(negedge Clk);
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", Busy); end
        checks++; if (PayloadReady !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", PayloadReady); end
        checks++; if (UartTxEnable !== 1'b0) begin errors++; $display("FAIL reset_en: got %b expected 0", UartTxEnable); end
        checks++; if (UartTxData !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", UartTxData); end
        Reset = 1'b0;
        repeat (2) @(negedge Clk);
        checks++; if (PayloadReady !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b expected 1", PayloadReady); end
    endtask

    task automatic test_basic();
        logic [7:0] exp [$];
        int base, pbase, n;
        bit ok;
        exp = '{8'hAA, 8'h03, 8'h01, 8'h02, 8'h03, 8'h03};
        base = cap_q.size(); pbase = pulses;
        write_byte(8'h01); write_byte(8'h02); write_byte(8'h03);
        send_packet();
        checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL basic_busy_high: got %b expected 1", Busy); end
        wait_idle(ok);
        checks++; if (!ok) begin errors++; $display("FAIL basic_timeout: busy stuck, expected idle"); end
        n = cap_q.size() - base;
        checks++;
        if (n != exp.size()) begin
            errors++; $display("FAIL basic_len: got %0d bytes expected %0d", n, exp.size());
        end else begin
            for (int i = 0; i < exp.size(); i++) begin
                checks++;
                if (cap_q[base+i] !== exp[i]) begin
                    errors++; $display("FAIL basic_byte%0d: got %h expected %h", i, cap_q[base+i], exp[i]);
                end
            end
        end
        checks++; if (pulses - pbase != 6) begin errors++; $display("FAIL basic_pulses: got %0d expected 6", pulses - pbase); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL basic_busy_low: got %b expected 0", Busy); end
        checks++; if (PayloadReady !== 1'b1) begin errors++; $display("FAIL basic_ready: got %b expected 1", PayloadReady); end
    endtask

    task automatic test_empty();
        logic [7:0] exp [$];
        int base, pbase, n;
        bit ok;
        exp = '{8'hAA, 8'h00, 8'h00};
        base = cap_q.size(); pbase = pulses;
        send_packet();
        wait_idle(ok);
        checks++; if (!ok) begin errors++; $display("FAIL empty_timeout: busy stuck, expected idle"); end
        n = cap_q.size() - base;
        checks++;
        if (n != exp.size()) begin
            errors++; $display("FAIL empty_len: got %0d bytes expected %0d", n, exp.size());
        end else begin
            for (int i = 0; i < exp.size(); i++) begin
                checks++;
                if (cap_q[base+i] !== exp[i]) begin
                    errors++; $display("FAIL empty_byte%0d: got %h expected %h", i, cap_q[base+i], exp[i]);
                end
            end
        end
        checks++; if (pulses - pbase != 3) begin errors++; $display("FAIL empty_pulses: got %0d expected 3", pulses - pbase); end
    endtask

    task automatic test_full();
        logic [7:0] exp [$];
        int base, pbase, n;
        bit ok;
        exp.push_back(8'hAA);
        exp.push_back(8'h10);
        for (int i = 0; i < 16; i++) exp.push_back(8'(8'h10 + i));
        exp.push_back(8'h10);
        base = cap_q.size(); pbase = pulses;
        for (int i = 0; i < 16; i++) write_byte(8'(8'h10 + i));
        checks++; if (PayloadReady !== 1'b0) begin errors++; $display("FAIL full_ready: got %b expected 0", PayloadReady); end
        write_byte(8'h20);
        send_packet();
        wait_idle(ok);
        checks++; if (!ok) begin errors++; $display("FAIL full_timeout: busy stuck, expected idle"); end
        n = cap_q.size() - base;
        checks++;
        if (n != exp.size()) begin
            errors++; $display("FAIL full_len: got %0d bytes expected %0d", n, exp.size());
        end else begin
            for (int i = 0; i < exp.size(); i++) begin
                checks++;
                if (cap_q[base+i] !== exp[i]) begin
                    errors++; $display("FAIL full_byte%0d: got %h expected %h", i, cap_q[base+i], exp[i]);
                end
            end
        end
        checks++; if (pulses - pbase != 19) begin errors++; $display("FAIL full_pulses: got %0d expected 19", pulses - pbase); end
    endtask

    task automatic test_slow_uart();
        logic [7:0] exp [$];
        int base, pbase, n;
        bit ok;
        exp = '{8'hAA, 8'h02, 8'hA5, 8'h3C, 8'h9B};
        uart_hold = 5;
        base = cap_q.size(); pbase = pulses;
        write_byte(8'hA5); write_byte(8'h3C);
        send_packet();
        wait_idle(ok);
        uart_hold = 0;
        checks++; if (!ok) begin errors++; $display("FAIL slow_timeout: busy stuck, expected idle"); end
        n = cap_q.size() - base;
        checks++;
        if (n != exp.size()) begin
            errors++; $display("FAIL slow_len: got %0d bytes expected %0d", n, exp.size());
        end else begin
            for (int i = 0; i < exp.size(); i++) begin
                checks++;
                if (cap_q[base+i] !== exp[i]) begin
                    errors++; $display("FAIL slow_byte%0d: got %h expected %h", i, cap_q[base+i], exp[i]);
                end
            end
        end
        checks++; if (pulses - pbase != 5) begin errors++; $display("FAIL slow_pulses: got %0d expected 5", pulses - pbase); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp [$];
        int base, pbase, n, p;
        bit ok;
        bit seen;
        exp = '{8'hAA, 8'h01, 8'h55, 8'h54};
        pbase = pulses;
        write_byte(8'h11); write_byte(8'h22); write_byte(8'h33);
        send_packet();
        seen = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge Clk);
            if (pulses - pbase >= 2) begin
                seen = 1'b1;
                break;
            end
        end
        checks++; if (!seen) begin errors++; $display("FAIL midrst_wait: got %0d pulses expected 2", pulses - pbase); end
        Reset = 1'b1;
        #1;
        p = pulses;
        checks++; if (UartTxEnable !== 1'b0) begin errors++; $display("FAIL midrst_en: got %b expected 0", UartTxEnable); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", Busy); end
        checks++; if (PayloadReady !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b expected 1", PayloadReady); end
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        repeat (20) @(negedge Clk);
        checks++; if (pulses != p) begin errors++; $display("FAIL midrst_no_pulse: got %0d pulses expected %0d", pulses, p); end
        base = cap_q.size(); pbase = pulses;
        write_byte(8'h55);
        send_packet();
        wait_idle(ok);
        checks++; if (!ok) begin errors++; $display("FAIL midrst_timeout: busy stuck, expected idle"); end
        n = cap_q.size() - base;
        checks++;
        if (n != exp.size()) begin
            errors++; $display("FAIL midrst_len: got %0d bytes expected %0d", n, exp.size());
        end else begin
            for (int i = 0; i < exp.size(); i++) begin
                checks++;
                if (cap_q[base+i] !== exp[i]) begin
                    errors++; $display("FAIL midrst_byte%0d: got %h expected %h", i, cap_q[base+i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_same_cycle();
        logic [7:0] exp [$];
        int base, n;
        bit ok;
        exp = '{8'hAA, 8'h01, 8'h7E, 8'h7F};
        base = cap_q.size();
        @(negedge Clk);
        PayloadData  = 8'h7E;
        PayloadValid = 1'b1;
        PacketSend   = 1'b1;
        @(negedge Clk);
        PayloadValid = 1'b0;
        PacketSend   = 1'b0;
        wait_idle(ok);
        checks++; if (!ok) begin errors++; $display("FAIL same_timeout: busy stuck, expected idle"); end
        n = cap_q.size() - base;
        checks++;
        if (n != exp.size()) begin
            errors++; $display("FAIL same_len: got %0d bytes expected %0d", n, exp.size());
        end else begin
            for (int i = 0; i < exp.size(); i++) begin
                checks++;
                if (cap_q[base+i] !== exp[i]) begin
                    errors++; $display("FAIL same_byte%0d: got %h expected %h", i, cap_q[base+i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp [$];
        int base, pbase, n;
        bit ok1, ok2;
        exp = '{8'hAA, 8'h01, 8'hFF, 8'hFE, 8'hAA, 8'h02, 8'h01, 8'h80, 8'h83};
        base = cap_q.size(); pbase = pulses;
        write_byte(8'hFF);
        send_packet();
        checks++; if (PayloadReady !== 1'b0) begin errors++; $display("FAIL b2b_ready_busy: got %b expected 0", PayloadReady); end
        // Both of these land while busy and must be dropped.
        write_byte(8'h99);
        send_packet();
        wait_idle(ok1);
        write_byte(8'h01); write_byte(8'h80);
        send_packet();
        wait_idle(ok2);
        checks++; if (!(ok1 && ok2)) begin errors++; $display("FAIL b2b_timeout: busy stuck, expected idle"); end
        n = cap_q.size() - base;
        checks++;
        if (n != exp.size()) begin
            errors++; $display("FAIL b2b_len: got %0d bytes expected %0d", n, exp.size());
        end else begin
            for (int i = 0; i < exp.size(); i++) begin
                checks++;
                if (cap_q[base+i] !== exp[i]) begin
                    errors++; $display("FAIL b2b_byte%0d: got %h expected %h", i, cap_q[base+i], exp[i]);
                end
            end
        end
        checks++; if (pulses - pbase != 9) begin errors++; $display("FAIL b2b_pulses: got %0d expected 9", pulses - pbase); end
    endtask

    task automatic test_handshake();
        checks++; if (consec_err != 0) begin errors++; $display("FAIL enable_consecutive: got %0d events expected 0", consec_err); end
        checks++; if (hold_err != 0) begin errors++; $display("FAIL data_hold: got %0d changes expected 0", hold_err); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_empty();
        test_full();
        test_slow_uart();
        test_reset_mid();
        test_same_cycle();
        test_back_to_back();
        test_handshake();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
